// File: rtl/xgmac_cfg_pkg.sv
// Shared definitions for the 10G MAC/PHY configuration master: command encodings,
// table entry layout, error codes and the default start-up command table.
package xgmac_cfg_pkg;

  localparam int ENTRY_W  = 78;
  localparam int MAX_CMDS = 256;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_POLL    = 2'd3
  } err_code_e;

  // Entry layout, MSB first: op[77:76], offset[75:64], data[63:32], mask[31:0].
  typedef struct packed {
    op_e         op;
    logic [11:0] offset;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  typedef logic [MAX_CMDS-1:0][ENTRY_W-1:0] table_t;

  function automatic cmd_t mk_cmd(input op_e op, input logic [11:0] offset,
                                  input logic [31:0] data, input logic [31:0] mask);
    cmd_t c;
    c.op     = op;
    c.offset = offset;
    c.data   = data;
    c.mask   = mask;
    return c;
  endfunction

  // MAC configuration, RX/TX enable, then wait for PCS block lock.
  function automatic table_t default_table();
    table_t t;
    for (int i = 0; i < MAX_CMDS; i++) t[i] = mk_cmd(OP_END, 12'h000, 32'h0, 32'h0);
    t[0] = mk_cmd(OP_WRITE, 12'h410, 32'h0000_2580, 32'h0);
    t[1] = mk_cmd(OP_WRITE, 12'h40C, 32'h6000_0000, 32'h0);
    t[2] = mk_cmd(OP_WRITE, 12'h404, 32'h9000_0000, 32'h0);
    t[3] = mk_cmd(OP_WRITE, 12'h408, 32'h9000_0000, 32'h0);
    t[4] = mk_cmd(OP_POLL,  12'h800, 32'h0000_0001, 32'h0000_0001);
    return t;
  endfunction

  localparam table_t DEFAULT_TABLE = default_table();

endpackage

// File: rtl/xgmac_cfg_rom.sv
// Combinational command table: index in, 78-bit packed entry out.
module xgmac_cfg_rom
  import xgmac_cfg_pkg::*;
#(
  parameter table_t C_TABLE = DEFAULT_TABLE
) (
  input  logic [7:0]         idx,
  output logic [ENTRY_W-1:0] entry
);

  assign entry = C_TABLE[idx];

endmodule

// File: rtl/xgmac_cfg_master.sv
// IPIF bus initiator: walks the command table and drives bus2ip_* transactions,
// reporting done/error status, the failing entry and the most recent read data.
module xgmac_cfg_master
  import xgmac_cfg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter int          C_NUM_CMDS    = 16,
  parameter int          C_ACK_TIMEOUT = 255,
  parameter int          C_POLL_MAX    = 1000,
  parameter int          C_POLL_GAP    = 64,
  parameter table_t      C_TABLE       = DEFAULT_TABLE
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_reset,
  input  logic        cfg_start,
  output logic        bus2ip_cs,
  output logic        bus2ip_rnw,
  output logic [31:0] bus2ip_addr,
  output logic [31:0] bus2ip_data,
  input  logic [31:0] ip2bus_data,
  input  logic        ip2bus_rdack,
  input  logic        ip2bus_wrack,
  input  logic        ip2bus_error,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [1:0]  cfg_err_code,
  output logic [7:0]  cfg_err_idx,
  output logic [31:0] cfg_rd_data
);

  localparam int IDX_W = (C_NUM_CMDS > 1) ? $clog2(C_NUM_CMDS) : 1;
  localparam int ATT_W = (C_POLL_MAX > 1) ? $clog2(C_POLL_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_EVAL, S_POLL_GAP, S_DONE, S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic               cs_q, cs_d, rnw_q, rnw_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  op_e                cur_op_q, cur_op_d;
  logic [31:0]        cmp_mask_q, cmp_mask_d, cmp_data_q, cmp_data_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  err_code_e          err_code_q, err_code_d;
  logic [7:0]         err_idx_q, err_idx_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic [7:0]         rom_idx;
  logic [ENTRY_W-1:0] rom_entry;
  cmd_t               entry;
  logic               ack, poll_ok, finish, abort;
  err_code_e          abort_code;

  // In EVAL the table is looked ahead by one so an END entry finishes without an extra cycle.
  assign rom_idx = 8'(idx_q) + 8'(state_q == S_EVAL);
  assign entry   = cmd_t'(rom_entry);

  xgmac_cfg_rom #(.C_TABLE(C_TABLE)) u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    attempt_d  = attempt_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cs_d       = cs_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cur_op_d   = cur_op_q;
    cmp_mask_d = cmp_mask_q;
    cmp_data_d = cmp_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    rd_data_d  = rd_data_q;
    ack        = 1'b0;
    poll_ok    = 1'b1;
    finish     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (cfg_start) begin
          state_d    = S_ISSUE;
          idx_d      = '0;
          attempt_d  = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          err_idx_d  = '0;
        end
      end

      S_ISSUE: begin
        if (entry.op == OP_END) begin
          finish = 1'b1;
        end else begin
          state_d    = S_WAIT_ACK;
          cs_d       = 1'b1;
          rnw_d      = (entry.op != OP_WRITE);
          addr_d     = C_BASEADDR + {20'd0, entry.offset};
          wdata_d    = (entry.op == OP_WRITE) ? entry.data : 32'h0;
          cur_op_d   = entry.op;
          cmp_mask_d = entry.mask;
          cmp_data_d = entry.data;
          to_cnt_d   = '0;
        end
      end

      S_WAIT_ACK: begin
        ack = rnw_q ? ip2bus_rdack : ip2bus_wrack;
        // An ack arriving on the timeout edge takes priority.
        if (ack) begin
          cs_d = 1'b0;
          if (rnw_q) rd_data_d = ip2bus_data;
          if (ip2bus_error) begin
            abort      = 1'b1;
            abort_code = ERR_BUS;
          end else begin
            state_d = S_EVAL;
          end
        end else if (int'(to_cnt_q) + 1 >= C_ACK_TIMEOUT) begin
          cs_d       = 1'b0;
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      S_EVAL: begin
        poll_ok = (cur_op_q != OP_POLL) ||
                  ((rd_data_q & cmp_mask_q) == (cmp_data_q & cmp_mask_q));
        if (!poll_ok) begin
          if (int'(attempt_q) + 1 >= C_POLL_MAX) begin
            abort      = 1'b1;
            abort_code = ERR_POLL;
          end else begin
            attempt_d = attempt_q + ATT_W'(1);
            gap_cnt_d = '0;
            state_d   = (C_POLL_GAP == 0) ? S_ISSUE : S_POLL_GAP;
          end
        end else begin
          attempt_d = '0;
          if ((int'(idx_q) == C_NUM_CMDS - 1) || (entry.op == OP_END)) begin
            finish = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ISSUE;
          end
        end
      end

      S_POLL_GAP: begin
        if (int'(gap_cnt_q) + 1 >= C_POLL_GAP) state_d = S_ISSUE;
        else gap_cnt_d = gap_cnt_q + 16'd1;
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (abort) begin
      state_d    = S_ERROR;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = abort_code;
      err_idx_d  = 8'(idx_q);
    end
  end

  always_ff @(posedge bus2ip_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (bus2ip_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      attempt_q  <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      cs_q       <= 1'b0;
      rnw_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      cur_op_q   <= OP_WRITE;
      cmp_mask_q <= '0;
      cmp_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      attempt_q  <= attempt_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cs_q       <= cs_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cur_op_q   <= cur_op_d;
      cmp_mask_q <= cmp_mask_d;
      cmp_data_q <= cmp_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus2ip_cs    = cs_q;
  assign bus2ip_rnw   = rnw_q;
  assign bus2ip_addr  = addr_q;
  assign bus2ip_data  = wdata_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_error    = error_q;
  assign cfg_err_code = err_code_q;
  assign cfg_err_idx  = err_idx_q;
  assign cfg_rd_data  = rd_data_q;

endmodule

// File: tb/tb_xgmac_cfg_master.sv
// Directed bench for xgmac_cfg_master: a task-driven IPIF responder checks each
// transaction against a scoreboard of expected bus cycles and checks status flags.
module tb_xgmac_cfg_master;
  import xgmac_cfg_pkg::*;

  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam int          ACK_TO   = 10;
  localparam int          POLL_MAX = 4;
  localparam int          POLL_GAP = 3;

  function automatic table_t tb_table();
    table_t t;
    for (int i = 0; i < MAX_CMDS; i++) t[i] = mk_cmd(OP_END, 12'h000, 32'h0, 32'h0);
    t[0] = mk_cmd(OP_WRITE, 12'h400, 32'h9000_0000, 32'h0);
    t[1] = mk_cmd(OP_READ,  12'h010, 32'h0,         32'h0);
    t[2] = mk_cmd(OP_WRITE, 12'h020, 32'h0000_00A5, 32'h0);
    t[3] = mk_cmd(OP_POLL,  12'h030, 32'h0000_0001, 32'h0000_0001);
    return t;
  endfunction

  localparam table_t TB_TABLE = tb_table();

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        bus2ip_clk = 1'b0;
  logic        bus2ip_reset;
  logic        cfg_start;
  logic        bus2ip_cs, bus2ip_rnw;
  logic [31:0] bus2ip_addr, bus2ip_data;
  logic [31:0] ip2bus_data;
  logic        ip2bus_rdack, ip2bus_wrack, ip2bus_error;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [1:0]  cfg_err_code;
  logic [7:0]  cfg_err_idx;
  logic [31:0] cfg_rd_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t sb[$];

  always #5 bus2ip_clk = ~bus2ip_clk;

  xgmac_cfg_master #(
    .C_BASEADDR    (BASE),
    .C_NUM_CMDS    (8),
    .C_ACK_TIMEOUT (ACK_TO),
    .C_POLL_MAX    (POLL_MAX),
    .C_POLL_GAP    (POLL_GAP),
    .C_TABLE       (TB_TABLE)
  ) dut (
    .bus2ip_clk   (bus2ip_clk),
    .bus2ip_reset (bus2ip_reset),
    .cfg_start    (cfg_start),
    .bus2ip_cs    (bus2ip_cs),
    .bus2ip_rnw   (bus2ip_rnw),
    .bus2ip_addr  (bus2ip_addr),
    .bus2ip_data  (bus2ip_data),
    .ip2bus_data  (ip2bus_data),
    .ip2bus_rdack (ip2bus_rdack),
    .ip2bus_wrack (ip2bus_wrack),
    .ip2bus_error (ip2bus_error),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .cfg_err_code (cfg_err_code),
    .cfg_err_idx  (cfg_err_idx),
    .cfg_rd_data  (cfg_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rnw, input logic [11:0] off, input logic [31:0] d);
    txn_t t;
    t.rnw  = rnw;
    t.addr = BASE + {20'd0, off};
    t.data = d;
    sb.push_back(t);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge bus2ip_clk);
    cfg_start = 1'b0;
  endtask

  // Waits for cs, checks the cycle against the scoreboard, holds for 'delay'
  // cycles (optionally with a wrong-type ack first), then acks.
  task automatic serve(input int delay, input logic [31:0] rdata, input logic err,
                       input logic wrong, output int wait_n);
    txn_t exp;
    logic stable;
    wait_n = 0;
    while (bus2ip_cs !== 1'b1 && wait_n < 100) begin
      @(negedge bus2ip_clk);
      wait_n++;
    end
    check("cs_rise", 32'(bus2ip_cs), 32'd1);
    if (bus2ip_cs !== 1'b1) return;
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 'x;
    check("addr", bus2ip_addr, exp.addr);
    check("rnw", 32'(bus2ip_rnw), 32'(exp.rnw));
    check("wdata", bus2ip_data, exp.data);
    if (wrong) begin
      if (exp.rnw) ip2bus_wrack = 1'b1;
      else ip2bus_rdack = 1'b1;
    end
    stable = 1'b1;
    repeat (delay) begin
      @(negedge bus2ip_clk);
      ip2bus_wrack = 1'b0;
      ip2bus_rdack = 1'b0;
      if (bus2ip_cs !== 1'b1 || bus2ip_addr !== exp.addr ||
          bus2ip_rnw !== exp.rnw || bus2ip_data !== exp.data) stable = 1'b0;
    end
    if (delay > 0) check("hold", 32'(stable), 32'd1);
    if (exp.rnw) ip2bus_rdack = 1'b1;
    else ip2bus_wrack = 1'b1;
    ip2bus_data  = rdata;
    ip2bus_error = err;
    @(negedge bus2ip_clk);
    ip2bus_rdack = 1'b0;
    ip2bus_wrack = 1'b0;
    ip2bus_error = 1'b0;
    ip2bus_data  = 32'h0;
    check("cs_drop", 32'(bus2ip_cs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   hi;
    logic seen;

    bus2ip_reset = 1'b1;
    cfg_start    = 1'b0;
    ip2bus_data  = 32'h0;
    ip2bus_rdack = 1'b0;
    ip2bus_wrack = 1'b0;
    ip2bus_error = 1'b0;
    repeat (3) @(negedge bus2ip_clk);
    check("rst_cs", 32'(bus2ip_cs), 32'd0);
    check("rst_rnw", 32'(bus2ip_rnw), 32'd1);
    check("rst_addr", bus2ip_addr, 32'h0);
    check("rst_flags", {26'd0, cfg_busy, cfg_done, cfg_error, cfg_err_code, 1'b0}, 32'h0);
    check("rst_rd_data", cfg_rd_data, 32'h0);
    bus2ip_reset = 1'b0;
    @(negedge bus2ip_clk);

    // Full run: write, read, write, poll that matches on the third attempt.
    push(1'b0, 12'h400, 32'h9000_0000);
    push(1'b1, 12'h010, 32'h0);
    push(1'b0, 12'h020, 32'h0000_00A5);
    repeat (3) push(1'b1, 12'h030, 32'h0);
    pulse_start();
    check("start_busy", 32'(cfg_busy), 32'd1);
    serve(3, 32'h0, 1'b0, 1'b0, n);
    check("start_latency", n, 1);
    serve(2, 32'hDEAD_BEEF, 1'b0, 1'b0, n);
    check("ack_to_next_cs", n, 2);
    check("rd_data", cfg_rd_data, 32'hDEAD_BEEF);
    pulse_start();
    check("busy_ignore_start", 32'(cfg_busy), 32'd1);
    serve(0, 32'h0, 1'b0, 1'b0, n);
    serve(0, 32'h0, 1'b0, 1'b0, n);
    serve(0, 32'h0, 1'b0, 1'b0, n);
    check("poll_gap1", n, 2 + POLL_GAP);
    serve(0, 32'h0000_0001, 1'b0, 1'b0, n);
    check("poll_gap2", n, 2 + POLL_GAP);
    check("done_not_yet", 32'(cfg_done), 32'd0);
    @(negedge bus2ip_clk);
    check("done", 32'(cfg_done), 32'd1);
    check("done_busy", 32'(cfg_busy), 32'd0);
    check("done_error", 32'(cfg_error), 32'd0);
    check("poll_rd_data", cfg_rd_data, 32'h0000_0001);

    // Poll that never matches: exactly POLL_MAX reads, then poll error.
    push(1'b0, 12'h400, 32'h9000_0000);
    push(1'b1, 12'h010, 32'h0);
    push(1'b0, 12'h020, 32'h0000_00A5);
    repeat (POLL_MAX) push(1'b1, 12'h030, 32'h0);
    pulse_start();
    check("restart_clears_done", 32'(cfg_done), 32'd0);
    serve(1, 32'h0, 1'b0, 1'b0, n);
    serve(1, 32'h1234_5678, 1'b0, 1'b0, n);
    serve(1, 32'h0, 1'b0, 1'b0, n);
    repeat (POLL_MAX) serve(0, 32'hFFFF_FFFE, 1'b0, 1'b0, n);
    @(negedge bus2ip_clk);
    check("poll_err", 32'(cfg_error), 32'd1);
    check("poll_err_code", 32'(cfg_err_code), 32'd3);
    check("poll_err_idx", 32'(cfg_err_idx), 32'd3);
    check("poll_fail_rd_data", cfg_rd_data, 32'hFFFF_FFFE);
    seen = 1'b0;
    repeat (12) begin
      @(negedge bus2ip_clk);
      if (bus2ip_cs !== 1'b0) seen = 1'b1;
    end
    check("no_extra_poll", 32'(seen), 32'd0);

    // Bus error on entry 2; wrong-type ack on the read is ignored.
    push(1'b0, 12'h400, 32'h9000_0000);
    push(1'b1, 12'h010, 32'h0);
    push(1'b0, 12'h020, 32'h0000_00A5);
    pulse_start();
    check("restart_clears_error", {29'd0, cfg_error, cfg_err_code}, 32'h0);
    serve(0, 32'h0, 1'b0, 1'b0, n);
    serve(2, 32'h0BAD_F00D, 1'b0, 1'b1, n);
    check("wrong_ack_rd_data", cfg_rd_data, 32'h0BAD_F00D);
    serve(1, 32'h0, 1'b1, 1'b0, n);
    check("bus_err", 32'(cfg_error), 32'd1);
    check("bus_err_code", 32'(cfg_err_code), 32'd1);
    check("bus_err_idx", 32'(cfg_err_idx), 32'd2);
    check("bus_err_busy", 32'(cfg_busy), 32'd0);

    // No ack at all: cs high for exactly ACK_TO cycles, then timeout error.
    pulse_start();
    n = 0;
    while (bus2ip_cs !== 1'b1 && n < 100) begin
      @(negedge bus2ip_clk);
      n++;
    end
    check("to_addr", bus2ip_addr, BASE + 32'h400);
    hi = 0;
    while (bus2ip_cs === 1'b1 && hi < 100) begin
      hi++;
      @(negedge bus2ip_clk);
    end
    check("to_cs_cycles", hi, ACK_TO);
    check("to_err", 32'(cfg_error), 32'd1);
    check("to_err_code", 32'(cfg_err_code), 32'd2);
    check("to_err_idx", 32'(cfg_err_idx), 32'd0);

    // Reset while waiting for an ack: cs drops next cycle, no retry.
    pulse_start();
    n = 0;
    while (bus2ip_cs !== 1'b1 && n < 100) begin
      @(negedge bus2ip_clk);
      n++;
    end
    check("rst_mid_cs", 32'(bus2ip_cs), 32'd1);
    bus2ip_reset = 1'b1;
    @(negedge bus2ip_clk);
    bus2ip_reset = 1'b0;
    check("rst_mid_cs_drop", 32'(bus2ip_cs), 32'd0);
    check("rst_mid_flags", {29'd0, cfg_busy, cfg_error, bus2ip_rnw}, 32'h1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge bus2ip_clk);
      if (bus2ip_cs !== 1'b0) seen = 1'b1;
    end
    check("rst_no_retry", 32'(seen), 32'd0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
